// File: rtl/oldland_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// oldland_bus_arbiter_pkg
//
// Shared definitions for the oldland memory-bus arbiter:
//   - one-hot arbiter state encodings (ARB_IDLE, ARB_GNT_I, ARB_GNT_D)
//   - master identifiers (ARB_MASTER_I, ARB_MASTER_D)
//   - the default i-side burst length. It is derived from the cache line size
//     in bytes, so the cache fill length and the arbiter burst length come
//     from one constant and cannot drift apart.
//   - rr_winner(): the round-robin choice when both masters are eligible.
// ----------------------------------------------------------------------------
package oldland_bus_arbiter_pkg;

   // Instruction cache line size in bytes.
   localparam int CACHE_LINE_SIZE = 32;

   // One i-side burst fills one cache line, one 32-bit word per beat.
   localparam int ARB_DEFAULT_BURST_WORDS = CACHE_LINE_SIZE / 4;

   typedef enum logic [2:0] {
      ARB_IDLE  = 3'b001,
      ARB_GNT_I = 3'b010,
      ARB_GNT_D = 3'b100
   } arb_state_e;

   typedef enum logic {
      ARB_MASTER_I = 1'b0,
      ARB_MASTER_D = 1'b1
   } arb_master_e;

   // The master that did not win the previous grant wins the next contention.
   function automatic arb_master_e rr_winner(arb_master_e last_grant);
      return (last_grant == ARB_MASTER_D) ? ARB_MASTER_I : ARB_MASTER_D;
   endfunction

endpackage

// File: rtl/oldland_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// oldland_bus_arbiter_if
//
// Bundles the three ports of the arbiter into one interface:
//   i_* : instruction-cache line-fill port (read-only bursts)
//   d_* : data port (single-beat read/write)
//   b_* : shared word-addressed memory bus
//
// Modports:
//   slave  : the arbiter. It serves the i/d requesters and drives the bus.
//   master : the surroundings. These are the requesters plus the memory slave.
// ----------------------------------------------------------------------------
interface oldland_bus_arbiter_if;

   // i-side
   logic        i_access;
   logic [29:0] i_addr;
   logic [31:0] i_data;
   logic        i_ack;
   logic        i_error;

   // d-side
   logic        d_access;
   logic [29:0] d_addr;
   logic        d_wr_en;
   logic [3:0]  d_bytesel;
   logic [31:0] d_wr_data;
   logic [31:0] d_data;
   logic        d_ack;
   logic        d_error;

   // memory bus
   logic        b_access;
   logic [29:0] b_addr;
   logic        b_wr_en;
   logic [3:0]  b_bytesel;
   logic [31:0] b_wr_data;
   logic [31:0] b_data;
   logic        b_ack;
   logic        b_error;

   modport slave (
      input  i_access, i_addr,
      output i_data, i_ack, i_error,
      input  d_access, d_addr, d_wr_en, d_bytesel, d_wr_data,
      output d_data, d_ack, d_error,
      output b_access, b_addr, b_wr_en, b_bytesel, b_wr_data,
      input  b_data, b_ack, b_error
   );

   modport master (
      output i_access, i_addr,
      input  i_data, i_ack, i_error,
      output d_access, d_addr, d_wr_en, d_bytesel, d_wr_data,
      input  d_data, d_ack, d_error,
      input  b_access, b_addr, b_wr_en, b_bytesel, b_wr_data,
      output b_data, b_ack, b_error
   );

endinterface

// File: rtl/oldland_arb_watchdog.sv
// ----------------------------------------------------------------------------
// oldland_arb_watchdog
//
// Bus-slave watchdog for the oldland arbiter. The top instantiates it only
// when OLDLAND_ARB_TIMEOUT_EN is defined.
//
// The counter is held at zero while no grant is active, and it clears on
// every b_ack. It increments on each granted cycle without an ack. On the
// TIMEOUT_CYCLES-th consecutive unacknowledged granted cycle, timeout is
// high for that cycle. The arbiter then ends the transfer through its
// normal error path.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   active     : a grant is in progress (arbiter not in IDLE)
//   b_ack      : bus beat complete
//   timeout    : combinational, high on the cycle the limit is reached
// ----------------------------------------------------------------------------
module oldland_arb_watchdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic b_ack,
   output logic timeout
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // count_q holds the number of unacknowledged cycles already completed.
   // The current cycle is therefore number count_q + 1.
   assign timeout = active && !b_ack && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
      count_d = count_q + 1'b1;
      if (!active || b_ack || timeout) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/oldland_bus_arbiter.sv
// ----------------------------------------------------------------------------
// oldland_bus_arbiter
//
// Merges the instruction-cache line-fill port (i-side, 8-beat read bursts)
// and the data port (d-side, single-beat read/write) onto one word-addressed
// memory bus.
//
// Arbitration:
//   - Grants are decided in IDLE and registered. A request therefore reaches
//     the bus one cycle after it is sampled, leaving a one-cycle bubble.
//   - When both masters contend, the grant goes to the master that did not
//     win last time. After reset, I wins the first contention.
//   - A grant is held for the whole i-side burst or the single d-side beat.
//   - After a completed transfer, a master must drop its access for one
//     cycle before it can be granted again. This rearm rule absorbs the
//     cache's trailing request cycle after its final ack.
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset, effective immediately
//   bus   : oldland_bus_arbiter_if.slave (i_*, d_* and b_* signals)
//
// Parameters:
//   I_BURST_WORDS  : beats per i-side burst; a power of two, at least 2
//   TIMEOUT_CYCLES : watchdog limit, used only with OLDLAND_ARB_TIMEOUT_EN
//
// Build option:
//   OLDLAND_ARB_TIMEOUT_EN - when defined, adds a watchdog. If the slave does
//   not ack within TIMEOUT_CYCLES, the arbiter forces ack+error to the granted
//   master. When undefined, a hung slave stalls the granted master forever.
// ----------------------------------------------------------------------------
module oldland_bus_arbiter
   import oldland_bus_arbiter_pkg::*;
#(
   parameter int I_BURST_WORDS  = ARB_DEFAULT_BURST_WORDS,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   oldland_bus_arbiter_if.slave   bus
);

   // Elaboration-time parameter checks.
   if (I_BURST_WORDS < 2 || (I_BURST_WORDS & (I_BURST_WORDS - 1)) != 0) begin : g_bad_burst
      $error("I_BURST_WORDS must be a power of two, at least 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   localparam int BEAT_W = $clog2(I_BURST_WORDS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(I_BURST_WORDS - 1);

   arb_state_e        state_q,      state_d;
   arb_master_e       last_grant_q, last_grant_d;
   logic [BEAT_W-1:0] beat_q,       beat_d;
   logic              i_rearm_q,    i_rearm_d;
   logic              d_rearm_q,    d_rearm_d;

   logic i_eligible;
   logic d_eligible;
   logic timeout;

   // -------------------------------------------------------------------------
   // Optional slave watchdog
   // -------------------------------------------------------------------------
`ifdef OLDLAND_ARB_TIMEOUT_EN
   oldland_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .active  (state_q != ARB_IDLE),
      .b_ack   (bus.b_ack),
      .timeout (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   assign i_eligible = bus.i_access && !i_rearm_q;
   assign d_eligible = bus.d_access && !d_rearm_q;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      beat_d       = beat_q;
      i_rearm_d    = i_rearm_q;
      d_rearm_d    = d_rearm_q;

      // Any idle-request cycle rearms a master. A completion in the same
      // cycle, assigned further down, takes precedence.
      if (!bus.i_access) i_rearm_d = 1'b0;
      if (!bus.d_access) d_rearm_d = 1'b0;

      unique case (state_q)
         ARB_IDLE: begin
            beat_d = '0;
            if (i_eligible && (!d_eligible || rr_winner(last_grant_q) == ARB_MASTER_I)) begin
               state_d      = ARB_GNT_I;
               last_grant_d = ARB_MASTER_I;
            end else if (d_eligible) begin
               state_d      = ARB_GNT_D;
               last_grant_d = ARB_MASTER_D;
            end
         end

         ARB_GNT_I: begin
            if (!bus.i_access) begin
               // Aborted fill: release the bus and do not demand a rearm.
               state_d = ARB_IDLE;
               beat_d  = '0;
            end else if (bus.b_error || timeout) begin
               state_d   = ARB_IDLE;
               beat_d    = '0;
               i_rearm_d = 1'b1;
            end else if (bus.b_ack) begin
               if (beat_q == LAST_BEAT) begin
                  state_d   = ARB_IDLE;
                  beat_d    = '0;
                  i_rearm_d = 1'b1;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end

         ARB_GNT_D: begin
            if (!bus.d_access) begin
               state_d = ARB_IDLE;
            end else if (bus.b_ack || bus.b_error || timeout) begin
               state_d   = ARB_IDLE;
               d_rearm_d = 1'b1;
            end
         end

         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARB_IDLE;
         last_grant_q <= ARB_MASTER_D;
         beat_q       <= '0;
         i_rearm_q    <= 1'b0;
         d_rearm_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         beat_q       <= beat_d;
         i_rearm_q    <= i_rearm_d;
         d_rearm_q    <= d_rearm_d;
      end
   end

   // -------------------------------------------------------------------------
   // Bus routing
   //
   // Routing is decoded from the registered state, and the granted master's
   // signals pass through combinationally. Reset forces IDLE asynchronously,
   // so all bus and ack/error outputs go to zero immediately.
   // -------------------------------------------------------------------------
   always_comb begin
      bus.b_access  = 1'b0;
      bus.b_addr    = '0;
      bus.b_wr_en   = 1'b0;
      bus.b_bytesel = '0;
      bus.b_wr_data = '0;
      bus.i_ack     = 1'b0;
      bus.i_error   = 1'b0;
      bus.d_ack     = 1'b0;
      bus.d_error   = 1'b0;

      // Read data is shared. Each master qualifies it with its own ack.
      bus.i_data    = bus.b_data;
      bus.d_data    = bus.b_data;

      unique case (state_q)
         ARB_GNT_I: begin
            bus.b_access = bus.i_access && !timeout;
            bus.b_addr   = bus.i_addr;
            bus.i_ack    = bus.b_ack || timeout;
            bus.i_error  = bus.b_error || timeout;
         end

         ARB_GNT_D: begin
            bus.b_access  = bus.d_access && !timeout;
            bus.b_addr    = bus.d_addr;
            bus.b_wr_en   = bus.d_wr_en;
            bus.b_bytesel = bus.d_bytesel;
            bus.b_wr_data = bus.d_wr_data;
            bus.d_ack     = bus.b_ack || timeout;
            bus.d_error   = bus.b_error || timeout;
         end

         default: ;
      endcase
   end

endmodule
